seven_seg_capture_decoder: RTL and testbench

//  Receive end of the multiplexed seven-segment interface: samples the abcdefgh/digit bus
//  (as driven to the display), filters glitches with a stability counter, and decodes each

---
 rtl/seven_seg_capture_decoder.sv | 131 +++++++++++++
 tb/tb_seven_seg_capture_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture_decoder.sv
// seven_seg_capture_decoder: samples a multiplexed seven-segment bus, debounces it,
// decodes each stable digit back to a character code and reports per-digit changes.
module seven_seg_capture_decoder #(
  parameter int w_digit       = 8,
  parameter int stable_cycles = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        abcdefgh_i,
  input  logic [w_digit-1:0]                digit_i,
  output logic [5*w_digit-1:0]              chars_o,
  output logic [w_digit-1:0]                dots_o,
  output logic                              upd_valid_o,
  input  logic                              upd_ready_i,
  output logic [$clog2(w_digit)-1:0]        upd_index_o,
  output logic [4:0]                        upd_char_o,
  output logic                              upd_dot_o,
  output logic                              upd_drop_o,
  output logic                              multi_err_o
);
  localparam int iw = $clog2(w_digit);
  localparam int cw = $clog2(stable_cycles + 1);

  logic [w_digit+7:0]       s_q, s_d, in_w;
  logic [cw-1:0]            cnt_q, cnt_d;
  logic [w_digit-1:0][4:0]  chars_q, chars_d;
  logic [w_digit-1:0]       dots_q, dots_d;
  logic                     valid_q, valid_d;
  logic [iw-1:0]            idx_q, idx_d, idx;
  logic [4:0]               char_q, char_d, dec;
  logic                     dot_q, dot_d, drop_q, drop_d, merr_q, merr_d;
  logic                     same, commit, onehot, wr, change, free, load;

  // segment pattern abcdefg back to character code; anything unrecognised is 0x1F
  always_comb begin
    dec = 5'h1F;
    case (abcdefgh_i[7:1])
      7'b1111110: dec = 5'h00;
      7'b0110000: dec = 5'h01;
      7'b1101101: dec = 5'h02;
      7'b1111001: dec = 5'h03;
      7'b0110011: dec = 5'h04;
      7'b1011011: dec = 5'h05;
      7'b1011111: dec = 5'h06;
      7'b1110000: dec = 5'h07;
      7'b1111111: dec = 5'h08;
      7'b1111011: dec = 5'h09;
      7'b1110111: dec = 5'h0A;
      7'b0011111: dec = 5'h0B;
      7'b1001110: dec = 5'h0C;
      7'b0111101: dec = 5'h0D;
      7'b1001111: dec = 5'h0E;
      7'b1000111: dec = 5'h0F;
      7'b1011110: dec = 5'h10;
      7'b1100111: dec = 5'h11;
      7'b0110111: dec = 5'h12;
      7'b0001110: dec = 5'h13;
      7'b0000000: dec = 5'h14;
      default:    dec = 5'h1F;
    endcase
  end

  // binary index of the selected digit and one-hot qualification
  always_comb begin
    idx = '0;
    for (int i = 0; i < w_digit; i++)
      if (digit_i[i]) idx = iw'(i);
    onehot = (digit_i != '0) && ((digit_i & (digit_i - w_digit'(1))) == '0);
  end

  // debounce, register-file write and single-slot event handshake
  always_comb begin
    in_w    = {digit_i, abcdefgh_i};
    same    = in_w == s_q;
    commit  = same && (cnt_q == cw'(stable_cycles - 1));
    s_d     = in_w;
    cnt_d   = !same ? '0 : (cnt_q == cw'(stable_cycles) ? cnt_q : cnt_q + cw'(1));
    wr      = commit && onehot;
    change  = wr && ({dec, abcdefgh_i[0]} != {chars_q[idx], dots_q[idx]});
    free    = !valid_q || upd_ready_i;
    load    = change && free;
    chars_d = chars_q;
    dots_d  = dots_q;
    if (wr) begin
      chars_d[idx] = dec;
      dots_d[idx]  = abcdefgh_i[0];
    end
    valid_d = load || (valid_q && !upd_ready_i);
    idx_d   = load ? idx : idx_q;
    char_d  = load ? dec : char_q;
    dot_d   = load ? abcdefgh_i[0] : dot_q;
    drop_d  = change && !free;
    merr_d  = commit && (digit_i != '0) && !onehot;
  end

  // state registers; blank slots reset to the space code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      cnt_q   <= '0;
      chars_q <= {w_digit{5'h14}};
      dots_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      char_q  <= '0;
      dot_q   <= 1'b0;
      drop_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      chars_q <= chars_d;
      dots_q  <= dots_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      dot_q   <= dot_d;
      drop_q  <= drop_d;
      merr_q  <= merr_d;
    end
  end

  assign chars_o     = chars_q;
  assign dots_o      = dots_q;
  assign upd_valid_o = valid_q;
  assign upd_index_o = idx_q;
  assign upd_char_o  = char_q;
  assign upd_dot_o   = dot_q;
  assign upd_drop_o  = drop_q;
  assign multi_err_o = merr_q;
endmodule

// File: tb/tb_seven_seg_capture_decoder.sv
// tb_seven_seg_capture_decoder: directed checks of debounce, decode, events and reset.
module tb_seven_seg_capture_decoder;
  logic        clk, rst_n;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [19:0] chars;
  logic [3:0]  dots;
  logic        upd_valid, upd_ready, upd_dot, upd_drop, multi_err;
  logic [1:0]  upd_index;
  logic [4:0]  upd_char;
  int          total = 0;
  int          passed = 0;

  seven_seg_capture_decoder #(.w_digit(4), .stable_cycles(4)) dut (
    .clk(clk), .rst_n(rst_n), .abcdefgh_i(abcdefgh), .digit_i(digit),
    .chars_o(chars), .dots_o(dots), .upd_valid_o(upd_valid), .upd_ready_i(upd_ready),
    .upd_index_o(upd_index), .upd_char_o(upd_char), .upd_dot_o(upd_dot),
    .upd_drop_o(upd_drop), .multi_err_o(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; abcdefgh = 8'h00; digit = 4'b0000; upd_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("reset_chars", chars, {4{5'h14}});
    chk("reset_dots", dots, 4'h0);
    chk("reset_valid", upd_valid, 1'b0);
    chk("reset_drop", upd_drop, 1'b0);
    digit = 4'b0001; abcdefgh = 8'b1000_1110;
    step(4);
    chk("f_early_chars", chars, {4{5'h14}});
    chk("f_early_valid", upd_valid, 1'b0);
    step(1);
    chk("f_chars", chars, {5'h14, 5'h14, 5'h14, 5'h0F});
    chk("f_valid", upd_valid, 1'b1);
    chk("f_index", upd_index, 2'd0);
    chk("f_char", upd_char, 5'h0F);
    chk("f_dot", upd_dot, 1'b0);
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
    chk("f_accepted", upd_valid, 1'b0);
    abcdefgh = 8'b1011_1100;
    step(2);
    abcdefgh = 8'b1011_1101;
    step(1);
    abcdefgh = 8'b1011_1100;
    step(4);
    chk("glitch_chars", chars[4:0], 5'h0F);
    chk("glitch_valid", upd_valid, 1'b0);
    step(1);
    chk("glitch_commit", chars[4:0], 5'h10);
    chk("glitch_ev", upd_char, 5'h10);
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
    chk("glitch_acc", upd_valid, 1'b0);
    digit = 4'b0110; abcdefgh = 8'b1111_1100;
    step(4);
    chk("multi_early", multi_err, 1'b0);
    step(1);
    chk("multi_pulse", multi_err, 1'b1);
    chk("multi_chars", chars, {5'h14, 5'h14, 5'h14, 5'h10});
    chk("multi_valid", upd_valid, 1'b0);
    step(1);
    chk("multi_end", multi_err, 1'b0);
    step(3);
    chk("multi_once", multi_err, 1'b0);
    digit = 4'b0010; abcdefgh = 8'b1011_1100;
    step(5);
    chk("g1_valid", upd_valid, 1'b1);
    chk("g1_index", upd_index, 2'd1);
    chk("g1_char", upd_char, 5'h10);
    chk("g1_drop", upd_drop, 1'b0);
    digit = 4'b0100; abcdefgh = 8'b1110_1110;
    step(5);
    chk("a2_chars", chars, {5'h14, 5'h0A, 5'h10, 5'h10});
    chk("a2_drop", upd_drop, 1'b1);
    chk("a2_valid", upd_valid, 1'b1);
    chk("a2_index", upd_index, 2'd1);
    chk("a2_char", upd_char, 5'h10);
    step(1);
    chk("a2_drop_end", upd_drop, 1'b0);
    chk("a2_hold", upd_index, 2'd1);
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
    chk("a2_acc", upd_valid, 1'b0);
    digit = 4'b1000; abcdefgh = 8'b1010_1010;
    step(5);
    chk("unk_char", chars[19:15], 5'h1F);
    chk("unk_dot", dots[3], 1'b0);
    chk("unk_index", upd_index, 2'd3);
    upd_ready = 1'b1;
    abcdefgh = 8'b1010_1011;
    step(1);
    upd_ready = 1'b0;
    step(4);
    chk("dot_valid", upd_valid, 1'b1);
    chk("dot_ev", upd_dot, 1'b1);
    chk("dot_reg", dots, 4'b1000);
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
    digit = 4'b0000;
    step(2);
    digit = 4'b1000;
    step(5);
    chk("same_noev", upd_valid, 1'b0);
    chk("same_dots", dots, 4'b1000);
    digit = 4'b0001; abcdefgh = 8'b0110_0000;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("rst_chars", chars, {4{5'h14}});
    chk("rst_dots", dots, 4'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("rst_nocommit", chars[4:0], 5'h14);
    chk("rst_novalid", upd_valid, 1'b0);
    step(2);
    chk("rst_recommit", chars[4:0], 5'h01);
    chk("rst_ev", upd_valid, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
